// File: rtl/calc_ctrl.sv
// calc_ctrl: sequences one request at a time through an external combinational ALU; result held until consumed.
// Latency: LAT edges accept-to-out_valid (add/sub 1, mul MUL_CYCLES, div DIV_CYCLES). Optional CALC_DIVZERO_CHECK_EN short-circuits divide-by-zero.
module calc_ctrl #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] in_a,
  input  logic [19:0] in_b,
  input  logic [1:0]  in_op,
  input  logic        in_chain,
  output logic [19:0] alu_a,
  output logic [19:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [19:0] alu_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_res,
  output logic        out_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;
  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] acc_q, acc_d;
  logic [19:0] a_q, a_d;
  logic [19:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [19:0] res_q, res_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;

  logic [19:0] eff_a;
  logic [3:0]  lat_cnt;
  logic        div_zero;

  always_comb begin
    eff_a = in_chain ? acc_q : in_a;
    case (in_op)
      OP_MUL:  lat_cnt = MUL_CNT;
      OP_DIV:  lat_cnt = DIV_CNT;
      default: lat_cnt = 4'd0;
    endcase
  end

`ifdef CALC_DIVZERO_CHECK_EN
  assign div_zero = (in_op == OP_DIV) && (in_b == 20'd0);
`else
  assign div_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    vld_d   = vld_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d  = eff_a;
          b_d  = in_b;
          op_d = in_op;
          if (div_zero) begin
            // Error result goes straight to HOLD; accumulator is left untouched.
            cnt_d   = 4'd0;
            res_d   = 20'hFFFFF;
            err_d   = 1'b1;
            vld_d   = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d   = lat_cnt;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d   = alu_res;
          acc_d   = alu_res;
          vld_d   = 1'b1;
          err_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      acc_q   <= 20'd0;
      a_q     <= 20'd0;
      b_q     <= 20'd0;
      op_q    <= 2'd0;
      res_q   <= 20'd0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign out_valid = vld_q;
  assign out_res   = res_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: behavioural ALU, vector table, scoreboard queue, reset/divzero sequences.
module tb_calc_ctrl;

  localparam int MUL_C = 2;
  localparam int DIV_C = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [19:0] in_a, in_b;
  logic [1:0]  in_op;
  logic        in_chain;
  logic [19:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [19:0] alu_res;
  logic        out_valid, out_ready;
  logic [19:0] out_res;
  logic        out_err;
  logic        busy;

  always #5 clk = ~clk;

  calc_ctrl #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_err(out_err), .busy(busy)
  );

  // External ALU model; divide by zero yields 0.
  logic [39:0] prod;
  always_comb begin
    prod = 40'(alu_a) * 40'(alu_b);
    case (alu_op)
      2'b00:   alu_res = alu_a + alu_b;
      2'b01:   alu_res = alu_a - alu_b;
      2'b10:   alu_res = prod[19:0];
      default: alu_res = (alu_b == 20'd0) ? 20'd0 : alu_a / alu_b;
    endcase
  end

  typedef struct {
    logic [19:0] a;
    logic [19:0] b;
    logic [1:0]  op;
    logic        ch;
    logic [19:0] res;
    logic        err;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [19:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [19:0] m_acc  = 20'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v);
    logic [19:0] ea;
    exp_t        e;
    int          edges;
    ea = v.ch ? m_acc : v.a;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    in_op    = v.op;
    in_chain = v.ch;
    e.res = v.res;
    e.err = v.err;
    e.lat = v.lat;
    sb.push_back(e);
    @(posedge clk); #1;
    // Junk request held high outside IDLE must be ignored.
    in_a     = 20'($urandom);
    in_b     = 20'($urandom);
    in_op    = 2'($urandom);
    in_chain = 1'($urandom);
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, v.b);
    chk("alu_op", alu_op, v.op);
    edges = 0;
    while (!out_valid && edges < 64) begin
      chk("busy_exec", busy, 1);
      @(posedge clk); #1;
      edges++;
      chk("alu_a_stable", alu_a, ea);
      chk("alu_b_stable", alu_b, v.b);
    end
    if (!out_valid) begin
      chk("out_valid_timeout", out_valid, 1);
    end else if (sb.size() == 0) begin
      chk("sb_nonempty", sb.size(), 1);
    end else begin
      e = sb.pop_front();
      chk("latency", edges, e.lat);
      chk("out_res", out_res, e.res);
      chk("out_err", out_err, e.err);
      for (int i = 0; i < v.hold; i++) begin
        @(posedge clk); #1;
        chk("hold_valid", out_valid, 1);
        chk("hold_res", out_res, e.res);
        chk("hold_in_ready", in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("retire_valid", out_valid, 0);
      chk("retire_idle", in_ready, 1);
      chk("retire_busy", busy, 0);
      if (!e.err) m_acc = e.res;
    end
    in_valid = 1'b0;
  endtask

  vec_t tbl[9];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    tbl[0] = '{20'd1234,   20'd10,   2'b10, 1'b0, 20'd12340,  1'b0, MUL_C, 1};
    tbl[1] = '{20'd5,      20'd3,    2'b00, 1'b0, 20'd8,      1'b0, 1,     1};
    tbl[2] = '{20'd999,    20'd2,    2'b01, 1'b1, 20'd6,      1'b0, 1,     5};
    tbl[3] = '{20'd100,    20'd4,    2'b11, 1'b0, 20'd25,     1'b0, DIV_C, 1};
    tbl[4] = '{20'd0,      20'd1,    2'b01, 1'b0, 20'hFFFFF,  1'b0, 1,     1};
    tbl[5] = '{20'd7,      20'd3,    2'b11, 1'b1, 20'h55555,  1'b0, DIV_C, 1};
    tbl[6] = '{20'd1000,   20'd1000, 2'b10, 1'b0, 20'hF4240,  1'b0, MUL_C, 1};
    tbl[7] = '{20'h80000,  20'd2,    2'b10, 1'b0, 20'd0,      1'b0, MUL_C, 1};
    tbl[8] = '{20'd10,     20'd20,   2'b00, 1'b1, 20'd20,     1'b0, 1,     1};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_chain = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_req(tbl[i]);

    // Divide by zero, then chain to see whether the accumulator moved.
`ifdef CALC_DIVZERO_CHECK_EN
    v = '{20'd7, 20'd0, 2'b11, 1'b0, 20'hFFFFF, 1'b1, 0, 2};
`else
    v = '{20'd7, 20'd0, 2'b11, 1'b0, 20'd0, 1'b0, DIV_C, 2};
`endif
    run_req(v);
    v = '{20'd0, 20'd1, 2'b00, 1'b1, m_acc + 20'd1, 1'b0, 1, 1};
    run_req(v);

    // Reset on the second EXEC edge of a divide discards it.
    @(negedge clk);
    in_valid = 1'b1; in_a = 20'd100; in_b = 20'd4; in_op = 2'b11; in_chain = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("div_busy", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_valid", seen, 0);
    m_acc = 20'd0;
    v = '{20'd777, 20'd5, 2'b00, 1'b1, 20'd5, 1'b0, 1, 1};
    run_req(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
